// File: rtl/seg_display_pkg.sv
// Shared constants for the product display: segment codes,
// converter state encoding and BCD nibble width.
package seg_display_pkg;

  localparam int BCD_W = 4;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
    8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  function automatic logic [7:0] seg_encode(
    input logic [BCD_W-1:0] d,
    input logic             blank
  );
    logic [7:0] r;
    r = SEG_BLANK;
    if (!blank && d <= 4'd9)
      r = SEG_DIGIT[d];
    return r;
  endfunction

endpackage

// File: rtl/bcd8_converter.sv
// Sequential shift-add-3 converter: 8-bit binary to three BCD digits,
// one LOAD cycle, eight SHIFT cycles, one DONE cycle.
module bcd8_converter
  import seg_display_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [7:0]       i_bin,
  output logic             o_busy,
  output logic             o_load,
  output logic             o_done,
  output logic [BCD_W-1:0] o_hundreds,
  output logic [BCD_W-1:0] o_tens,
  output logic [BCD_W-1:0] o_ones
);

  conv_state_t r_state;
  conv_state_t w_next;
  logic [19:0] r_sr;
  logic [19:0] w_adj;
  logic [2:0]  r_cnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_SHIFT;
      ST_SHIFT: if (r_cnt == 3'd7) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Add-3 correction happens on the pre-shift value of each nibble.
  always_comb begin
    w_adj = r_sr;
    for (int i = 0; i < 3; i++) begin
      if (w_adj[8+4*i +: 4] >= 4'd5)
        w_adj[8+4*i +: 4] = w_adj[8+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_LOAD: begin
          r_sr  <= {12'd0, i_bin};
          r_cnt <= '0;
        end
        ST_SHIFT: begin
          r_sr  <= {w_adj[18:0], 1'b0};
          r_cnt <= r_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != ST_IDLE);
  assign o_load     = (r_state == ST_LOAD);
  assign o_done     = (r_state == ST_DONE);
  assign o_hundreds = r_sr[19:16];
  assign o_tens     = r_sr[15:12];
  assign o_ones     = r_sr[11:8];

endmodule

// File: rtl/product_seg_display.sv
// Shows A, B and A*B in decimal on the eight 7-segment digits
// using a sampled snapshot, a BCD converter and a 4-slot scan.
module product_seg_display
  import seg_display_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk_pin,
  input  logic       rst_n_pin,
  input  logic [3:0] operand_a,
  input  logic [3:0] operand_b,
  input  logic [7:0] product,
  output logic [7:0] an_pin,
  output logic [7:0] seg1_pin,
  output logic [7:0] seg0_pin
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [15:0]      r_snap;
  logic             w_start;
  logic             w_busy;
  logic             w_load;
  logic             w_done;
  logic [BCD_W-1:0] w_h;
  logic [BCD_W-1:0] w_t;
  logic [BCD_W-1:0] w_o;

  logic [3:0]       r_disp_a;
  logic [3:0]       r_disp_b;
  logic [BCD_W-1:0] r_disp_h;
  logic [BCD_W-1:0] r_disp_t;
  logic [BCD_W-1:0] r_disp_o;

  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_slot;

  assign w_start = !w_busy &&
                   ({operand_a, operand_b, product} != r_snap);

  bcd8_converter u_conv (
    .i_clk      (clk_pin),
    .i_rst_n    (rst_n_pin),
    .i_start    (w_start),
    .i_bin      (product),
    .o_busy     (w_busy),
    .o_load     (w_load),
    .o_done     (w_done),
    .o_hundreds (w_h),
    .o_tens     (w_t),
    .o_ones     (w_o)
  );

  // Display registers move only in DONE so a frame is never mixed.
  always_ff @(posedge clk_pin) begin
    if (!rst_n_pin) begin
      r_snap   <= '0;
      r_disp_a <= '0;
      r_disp_b <= '0;
      r_disp_h <= '0;
      r_disp_t <= '0;
      r_disp_o <= '0;
    end else begin
      if (w_load)
        r_snap <= {operand_a, operand_b, product};
      if (w_done) begin
        r_disp_a <= r_snap[15:12];
        r_disp_b <= r_snap[11:8];
        r_disp_h <= w_h;
        r_disp_t <= w_t;
        r_disp_o <= w_o;
      end
    end
  end

  logic       w_a_ten;
  logic       w_b_ten;
  logic [3:0] w_a_one;
  logic [3:0] w_b_one;

  assign w_a_ten = (r_disp_a >= 4'd10);
  assign w_b_ten = (r_disp_b >= 4'd10);
  assign w_a_one = r_disp_a - (w_a_ten ? 4'd10 : 4'd0);
  assign w_b_one = r_disp_b - (w_b_ten ? 4'd10 : 4'd0);

  logic [7:0] w_an;
  logic [7:0] w_seg1;
  logic [7:0] w_seg0;

  always_comb begin
    w_an   = (8'h80 >> r_slot) | (8'h08 >> r_slot);
    w_seg1 = SEG_BLANK;
    w_seg0 = SEG_BLANK;
    case (r_slot)
      2'd0: begin
        w_seg1 = seg_encode({3'd0, w_a_ten}, !w_a_ten);
        w_seg0 = SEG_BLANK;
      end
      2'd1: begin
        w_seg1 = seg_encode(w_a_one, 1'b0);
        w_seg0 = seg_encode(r_disp_h, r_disp_h == 4'd0);
      end
      2'd2: begin
        w_seg1 = seg_encode({3'd0, w_b_ten}, !w_b_ten);
        w_seg0 = seg_encode(r_disp_t,
                   (r_disp_h == 4'd0) && (r_disp_t == 4'd0));
      end
      default: begin
        w_seg1 = seg_encode(w_b_one, 1'b0);
        w_seg0 = seg_encode(r_disp_o, 1'b0);
      end
    endcase
  end

  always_ff @(posedge clk_pin) begin
    if (!rst_n_pin) begin
      r_pre    <= '0;
      r_slot   <= '0;
      an_pin   <= '0;
      seg1_pin <= '0;
      seg0_pin <= '0;
    end else begin
      if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
        r_pre  <= '0;
        r_slot <= r_slot + 2'd1;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      an_pin   <= w_an;
      seg1_pin <= w_seg1;
      seg0_pin <= w_seg0;
    end
  end

endmodule
